// File: rtl/dmem_responder.sv
// Slave end of the DMEM interface: one load/store at a time, committed against a
// word-organized array after a fixed latency, answered through a valid/ready response.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_rsel,
    input  logic [1:0]  req_wsel,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    rsel_q, rsel_d;
    logic [1:0]    wsel_q, wsel_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic          commit;
    logic          mem_we;
    logic [31:0]   merged_word;

    logic          oob, sel_bad, is_half, is_word, misaligned, err;
    logic [4:0]    lane_sh;
    logic [31:0]   lane_mask;
    logic [31:0]   lane_word;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_v;

    assign word_idx = addr_q[AW+1:2];
    assign cur_word = mem_q[word_idx];
    assign commit   = (state_q == S_WAIT) && (cnt_q == '0);

    // Error classification and lane extraction for the captured request
    always_comb begin
        oob = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
        if (we_q) begin
            sel_bad = (wsel_q == 2'd3);
            is_half = (wsel_q == 2'd1);
            is_word = (wsel_q == 2'd2);
        end else begin
            sel_bad = (rsel_q == 3'd3) || (rsel_q[2:1] == 2'b11);
            is_half = (rsel_q[1:0] == 2'b01);
            is_word = (rsel_q == 3'd2);
        end
        misaligned = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
        err        = oob || sel_bad || misaligned;

        lane_word = cur_word >> {addr_q[1:0], 3'b000};
        byte_v    = lane_word[7:0];
        half_v    = addr_q[1] ? cur_word[31:16] : cur_word[15:0];

        case (rsel_q)
            3'd0:    load_v = {{24{byte_v[7]}}, byte_v};
            3'd1:    load_v = {{16{half_v[15]}}, half_v};
            3'd2:    load_v = cur_word;
            3'd4:    load_v = {24'h000000, byte_v};
            3'd5:    load_v = {16'h0000, half_v};
            default: load_v = 32'h0000_0000;
        endcase
    end

    // Read-modify-write merge: only the addressed lanes take store data
    always_comb begin
        case (wsel_q)
            2'd0: begin
                lane_sh   = {addr_q[1:0], 3'b000};
                lane_mask = 32'h0000_00FF << lane_sh;
            end
            2'd1: begin
                lane_sh   = {addr_q[1], 4'b0000};
                lane_mask = 32'h0000_FFFF << lane_sh;
            end
            default: begin
                lane_sh   = 5'd0;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
        merged_word = (cur_word & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
        mem_we      = commit && we_q && !err;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsel_d       = rsel_q;
        wsel_d       = wsel_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rsel_d      = req_rsel;
                    wsel_d      = req_wsel;
                    cnt_d       = CW'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = err;
                    resp_rdata_d = (we_q || err) ? 32'h0000_0000 : load_v;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0000_0000;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            rsel_q       <= 3'd0;
            wsel_q       <= 2'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsel_q       <= rsel_d;
            wsel_q       <= wsel_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Array is deliberately not reset; writes happen only on the commit edge
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/timing,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_rsel;
    logic [1:0]  req_wsel;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        t_req_valid, t_req_ready, t_req_we;
    logic [31:0] t_req_addr, t_req_wdata;
    logic [2:0]  t_req_rsel;
    logic [1:0]  t_req_wsel;
    logic        t_resp_valid, t_resp_ready, t_resp_err;
    logic [31:0] t_resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rsel(req_rsel), .req_wsel(req_wsel),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(t_req_we),
        .req_addr(t_req_addr), .req_wdata(t_req_wdata), .req_rsel(t_req_rsel), .req_wsel(t_req_wsel),
        .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
        .resp_rdata(t_resp_rdata), .resp_err(t_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on the LATENCY=2 instance; entered and left #1 after a rising edge in IDLE
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] rsel, input logic [1:0] wsel,
                          output logic [31:0] rdata, output logic err, output int lat);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_rsel = rsel; req_wsel = wsel;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A;
        req_rsel = 3'd7; req_wsel = 2'd3;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        if (resp_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_rsel = '0; req_wsel = '0;
        resp_ready = 1'b1;
        t_req_valid = 1'b0; t_req_we = 1'b0; t_req_addr = '0; t_req_wdata = '0; t_req_rsel = '0; t_req_wsel = '0;
        t_resp_ready = 1'b1;
        #7;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_round_trip();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0, 2'd2, rd, er, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sw_err: got %b expected 0", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL sw_rdata: got %h expected 0", rd); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL sw_valid_one_cycle: got %b expected 0", resp_valid); end
        do_txn(1'b0, 32'h10, 32'h0, 3'd2, 2'd0, rd, er, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lw_err: got %b expected 0", er); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'h20, 32'h0000_0000, 3'd0, 2'd2, rd, er, lat);
        do_txn(1'b1, 32'h23, 32'h1234_5680, 3'd0, 2'd0, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sb_err: got %b expected 0", er); end
        do_txn(1'b0, 32'h20, 32'h0, 3'd2, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'h8000_0000) begin n_bad++; $display("FAIL lw_after_sb: got %h expected 80000000", rd); end
        do_txn(1'b0, 32'h23, 32'h0, 3'd0, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb: got %h expected ffffff80", rd); end
        do_txn(1'b0, 32'h23, 32'h0, 3'd4, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu: got %h expected 00000080", rd); end
        do_txn(1'b0, 32'h22, 32'h0, 3'd1, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFF_8000) begin n_bad++; $display("FAIL lh: got %h expected ffff8000", rd); end
        do_txn(1'b0, 32'h22, 32'h0, 3'd5, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0000_8000) begin n_bad++; $display("FAIL lhu: got %h expected 00008000", rd); end
        do_txn(1'b1, 32'h24, 32'h1122_3344, 3'd0, 2'd2, rd, er, lat);
        do_txn(1'b1, 32'h26, 32'hFFFF_A5B6, 3'd0, 2'd1, rd, er, lat);
        do_txn(1'b0, 32'h24, 32'h0, 3'd2, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'hA5B6_3344) begin n_bad++; $display("FAIL sh_upper_lane: got %h expected a5b63344", rd); end
        do_txn(1'b0, 32'h25, 32'h0, 3'd4, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0000_0033) begin n_bad++; $display("FAIL lbu_lane1: got %h expected 00000033", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b0, 32'h21, 32'h0, 3'd1, 2'd0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL lh_misaligned_err: got %b expected 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL lh_misaligned_rdata: got %h expected 0", rd); end
        do_txn(1'b1, 32'h22, 32'hFFFF_FFFF, 3'd0, 2'd2, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL sw_misaligned_err: got %b expected 1", er); end
        do_txn(1'b1, 32'h20, 32'hFFFF_FFFF, 3'd0, 2'd3, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL wsel3_err: got %b expected 1", er); end
        do_txn(1'b0, 32'h20, 32'h0, 3'd2, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'h8000_0000) begin n_bad++; $display("FAIL err_store_no_write: got %h expected 80000000", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL err_store_no_write_err: got %b expected 0", er); end
        do_txn(1'b0, 32'h0000_1000, 32'h0, 3'd2, 2'd0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oob_err: got %b expected 1", er); end
        do_txn(1'b0, 32'h0000_0FFC, 32'h0, 3'd2, 2'd0, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL last_word_err: got %b expected 0", er); end
        do_txn(1'b0, 32'h20, 32'h0, 3'd3, 2'd0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL rsel3_err: got %b expected 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rsel3_rdata: got %h expected 0", rd); end
        do_txn(1'b0, 32'h20, 32'h0, 3'd6, 2'd0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL rsel6_err: got %b expected 1", er); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_rsel = 3'd2; req_wsel = 2'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_latency: got %0d expected 2", lat); end
        // A store offered while the response is stalled must be ignored
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wsel = 2'd2;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); end
            n_cmp++; if (resp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bp_rdata[%0d]: got %h expected deadbeef", i, resp_rdata); end
            n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL bp_err[%0d]: got %b expected 0", i, resp_err); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
        do_txn(1'b0, 32'h10, 32'h0, 3'd2, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bp_ignored_store: got %h expected deadbeef", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'h40, 32'h0000_0000, 3'd0, 2'd2, rd, er, lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h1234_5678; req_wsel = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_wait_req_ready: got %b expected 0", req_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wait_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wait_ready: got %b expected 1", req_ready); end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wait_no_resp: got %b expected 0", resp_valid); end
        do_txn(1'b0, 32'h40, 32'h0, 3'd2, 2'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_wait_no_commit: got %h expected 0", rd); end
    endtask

    task automatic drive_t(input int k);
        if (k < 10) begin
            t_req_we    = 1'b1;
            t_req_addr  = 32'h100 + 32'(4 * k);
            t_req_wdata = 32'hA000_0000 + 32'(k) * 32'h0101_0101;
            t_req_wsel  = 2'd2;
            t_req_rsel  = 3'd0;
        end else begin
            t_req_we    = 1'b0;
            t_req_addr  = 32'h100 + 32'(4 * (k - 10));
            t_req_wdata = 32'h0;
            t_req_wsel  = 2'd0;
            t_req_rsel  = 3'd2;
        end
    endtask

    task automatic test_throughput();
        int acc[20];
        int k = 0;
        int r = 0;
        int cyc = 0;
        logic rdy;
        logic [31:0] exp_d;
        t_resp_ready = 1'b1;
        drive_t(0);
        t_req_valid = 1'b1;
        while (r < 20 && cyc < 200) begin
            @(negedge clk);
            rdy = t_req_ready;
            if (t_resp_valid) begin
                exp_d = (r < 10) ? 32'h0 : 32'hA000_0000 + 32'(r - 10) * 32'h0101_0101;
                n_cmp++; if (t_resp_rdata !== exp_d) begin n_bad++; $display("FAIL tput_rdata[%0d]: got %h expected %h", r, t_resp_rdata, exp_d); end
                n_cmp++; if (t_resp_err !== 1'b0) begin n_bad++; $display("FAIL tput_err[%0d]: got %b expected 0", r, t_resp_err); end
                r++;
            end
            @(posedge clk);
            if (rdy && k < 20) begin
                acc[k] = cyc;
                k++;
                #1;
                if (k < 20) drive_t(k);
                else t_req_valid = 1'b0;
            end
            cyc++;
        end
        n_cmp++; if (r !== 20) begin n_bad++; $display("FAIL tput_resp_count: got %0d expected 20", r); end
        for (int i = 1; i < k; i++) begin
            n_cmp++; if (acc[i] - acc[i-1] !== 3) begin n_bad++; $display("FAIL tput_spacing[%0d]: got %0d expected 3", i, acc[i] - acc[i-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_throughput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
